// File: rtl/recog_frame_sched.sv
// Frame-level sequencer for the digit-recognition pipeline: IDLE -> PROJ -> RECOG -> HOLD, with result stabilisation.
// Optional statistics counters (recog_count, timeout_count) are enabled with the RECOG_STAT_EN macro.
module recog_frame_sched #(
  parameter int STABLE_N    = 3,
  parameter int MAX_RETRY   = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       frame_vsync,
  input  logic       project_done_flag,
  input  logic [3:0] digit_in,
  output logic [1:0] frame_cnt,
  output logic       proj_en,
  output logic       recog_en,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       err,
  output logic       busy
`ifdef RECOG_STAT_EN
  ,
  output logic [15:0] recog_count,
  output logic [7:0]  timeout_count
`endif
);

  typedef enum logic [1:0] {IDLE, PROJ, RECOG, HOLD} state_t;

  localparam logic [3:0] STABLE_W = 4'(STABLE_N);
  localparam logic [3:0] RETRY_W  = 4'(MAX_RETRY);
  localparam logic [3:0] HOLD_W   = 4'(HOLD_FRAMES);
  localparam bit         HAS_HOLD = (HOLD_FRAMES > 0);

  state_t     state, state_n;
  logic       vsync_d, frame_start, done_seen, done_now;
  logic [3:0] retry_cnt, hold_cnt, cand, stable_cnt;
  logic [3:0] stable_nxt, cand_nxt;
  logic       publish;
  logic       clr_retry, inc_retry, set_err, clr_err, clr_hold, inc_hold, do_sample, to_idle;

  assign frame_start = frame_vsync & ~vsync_d;
  assign done_now    = done_seen | project_done_flag;
  assign busy        = (state != IDLE);

  // Result filter: an invalid sample breaks the run; a differing valid sample starts a new run.
  always_comb begin
    stable_nxt = 4'd1;
    cand_nxt   = cand;
    if (digit_in >= 4'd10) begin
      stable_nxt = 4'd0;
    end else if (digit_in == cand && stable_cnt != 4'd0) begin
      stable_nxt = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
    end else begin
      cand_nxt   = digit_in;
    end
    publish = (stable_nxt == STABLE_W);
  end

  always_comb begin
    state_n   = state;
    clr_retry = 1'b0;
    inc_retry = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    clr_hold  = 1'b0;
    inc_hold  = 1'b0;
    do_sample = 1'b0;
    if (frame_start) begin
      case (state)
        IDLE: if (run) begin
          state_n   = PROJ;
          clr_retry = 1'b1;
          clr_err   = 1'b1;
        end
        PROJ: begin
          if (!run) begin
            state_n = IDLE;
          end else if (done_now) begin
            state_n = RECOG;
          end else if (retry_cnt + 4'd1 == RETRY_W) begin
            state_n = IDLE;
            set_err = 1'b1;
          end else begin
            inc_retry = 1'b1;
          end
        end
        RECOG: begin
          do_sample = 1'b1;
          if (!run) begin
            state_n = IDLE;
          end else if (HAS_HOLD) begin
            state_n  = HOLD;
            clr_hold = 1'b1;
          end else begin
            state_n   = PROJ;
            clr_retry = 1'b1;
          end
        end
        HOLD: begin
          if (!run) begin
            state_n = IDLE;
          end else if (hold_cnt + 4'd1 == HOLD_W) begin
            state_n   = PROJ;
            clr_retry = 1'b1;
          end else begin
            inc_hold = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    to_idle = (state_n == IDLE) && (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_d     <= 1'b1;
      done_seen   <= 1'b0;
      retry_cnt   <= 4'd0;
      hold_cnt    <= 4'd0;
      cand        <= 4'd0;
      stable_cnt  <= 4'd0;
      digit       <= 4'hF;
      digit_valid <= 1'b0;
      err         <= 1'b0;
      frame_cnt   <= 2'd0;
      proj_en     <= 1'b0;
      recog_en    <= 1'b0;
    end else begin
      state   <= state_n;
      vsync_d <= frame_vsync;
      if (frame_start)            done_seen <= 1'b0;
      else if (project_done_flag) done_seen <= 1'b1;
      if (clr_retry)      retry_cnt <= 4'd0;
      else if (inc_retry) retry_cnt <= retry_cnt + 4'd1;
      if (clr_hold)      hold_cnt <= 4'd0;
      else if (inc_hold) hold_cnt <= hold_cnt + 4'd1;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      digit_valid <= do_sample & publish;
      if (do_sample && publish) digit <= cand_nxt;
      // The final RECOG sample still publishes before IDLE wipes the candidate.
      if (to_idle) begin
        cand       <= 4'd0;
        stable_cnt <= 4'd0;
      end else if (do_sample) begin
        cand       <= cand_nxt;
        stable_cnt <= publish ? 4'd0 : stable_nxt;
      end
      frame_cnt <= (state_n == PROJ) ? 2'd1 : (state_n == RECOG) ? 2'd2 : 2'd0;
      proj_en   <= (state_n == PROJ);
      recog_en  <= (state_n == RECOG);
    end
  end

`ifdef RECOG_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      recog_count   <= 16'd0;
      timeout_count <= 8'd0;
    end else begin
      if (do_sample && publish && recog_count != 16'hFFFF) recog_count <= recog_count + 16'd1;
      if (set_err && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_recog_frame_sched.sv
// Bench for recog_frame_sched: behavioural frame model compared every cycle, plus directed literal checks.
module tb_recog_frame_sched;
  localparam int STABLE_N    = 3;
  localparam int MAX_RETRY   = 4;
  localparam int HOLD_FRAMES = 2;
  localparam int P_IDLE = 0, P_PROJ = 1, P_RECOG = 2, P_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n, run, frame_vsync, project_done_flag;
  logic [3:0] digit_in;
  logic [1:0] frame_cnt;
  logic       proj_en, recog_en, digit_valid, err, busy;
  logic [3:0] digit;
`ifdef RECOG_STAT_EN
  logic [15:0] recog_count;
  logic [7:0]  timeout_count;
`endif

  always #5 clk = ~clk;

  recog_frame_sched #(.STABLE_N(STABLE_N), .MAX_RETRY(MAX_RETRY), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_vsync(frame_vsync),
    .project_done_flag(project_done_flag), .digit_in(digit_in),
    .frame_cnt(frame_cnt), .proj_en(proj_en), .recog_en(recog_en),
    .digit(digit), .digit_valid(digit_valid), .err(err), .busy(busy)
`ifdef RECOG_STAT_EN
    , .recog_count(recog_count), .timeout_count(timeout_count)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  // Behavioural model: phase of the frame schedule plus the run of recent equal samples.
  int         m_phase, m_retry, m_hold, m_recog, m_tmo;
  bit         m_vsd, m_done, m_dv, m_err;
  logic [3:0] m_digit;
  int         hist[$];

  bit         cap_dv;
  logic [1:0] cap_fc;
  int         fc_log[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic go_idle();
    m_phase = P_IDLE;
    hist.delete();
  endtask

  task automatic sample(input logic [3:0] din);
    if (din >= 4'd10) begin
      hist.delete();
    end else begin
      if (hist.size() > 0 && hist[$] != int'(din)) hist.delete();
      hist.push_back(int'(din));
      if (hist.size() == STABLE_N) begin
        m_digit = din;
        m_dv    = 1'b1;
        if (m_recog < 65535) m_recog++;
        hist.delete();
      end
    end
  endtask

  task automatic model_step(input bit r_n, input bit rn, input bit vs, input bit pdf, input logic [3:0] din);
    bit fs, dn;
    m_dv = 1'b0;
    if (!r_n) begin
      go_idle();
      m_vsd = 1'b1; m_done = 1'b0; m_retry = 0; m_hold = 0;
      m_digit = 4'hF; m_err = 1'b0; m_recog = 0; m_tmo = 0;
      return;
    end
    fs    = vs && !m_vsd;
    m_vsd = vs;
    if (!fs) begin
      if (pdf) m_done = 1'b1;
      return;
    end
    dn     = m_done || pdf;
    m_done = 1'b0;
    case (m_phase)
      P_IDLE: if (rn) begin m_phase = P_PROJ; m_retry = 0; m_err = 1'b0; end
      P_PROJ: begin
        if (!rn) go_idle();
        else if (dn) m_phase = P_RECOG;
        else begin
          m_retry++;
          if (m_retry == MAX_RETRY) begin
            go_idle();
            m_err = 1'b1;
            if (m_tmo < 255) m_tmo++;
          end
        end
      end
      P_RECOG: begin
        sample(din);
        if (!rn) go_idle();
        else if (HOLD_FRAMES > 0) begin m_phase = P_HOLD; m_hold = 0; end
        else begin m_phase = P_PROJ; m_retry = 0; end
      end
      default: begin
        if (!rn) go_idle();
        else begin
          m_hold++;
          if (m_hold == HOLD_FRAMES) begin m_phase = P_PROJ; m_retry = 0; end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [1:0] efc;
    efc = (m_phase == P_PROJ) ? 2'd1 : (m_phase == P_RECOG) ? 2'd2 : 2'd0;
    chk("frame_cnt", 16'(frame_cnt), 16'(efc));
    chk("proj_en", 16'(proj_en), 16'(m_phase == P_PROJ));
    chk("recog_en", 16'(recog_en), 16'(m_phase == P_RECOG));
    chk("busy", 16'(busy), 16'(m_phase != P_IDLE));
    chk("digit", 16'(digit), 16'(m_digit));
    chk("digit_valid", 16'(digit_valid), 16'(m_dv));
    chk("err", 16'(err), 16'(m_err));
`ifdef RECOG_STAT_EN
    chk("recog_count", recog_count, 16'(m_recog));
    chk("timeout_count", 16'(timeout_count), 16'(m_tmo));
`endif
  endtask

  task automatic tick(input bit r_n, input bit rn, input bit vs, input bit pdf, input logic [3:0] din);
    rst_n = r_n; run = rn; frame_vsync = vs; project_done_flag = pdf; digit_in = din;
    model_step(r_n, rn, vs, pdf, din);
    @(negedge clk);
    check_outputs();
  endtask

  // One 3-cycle frame; outputs right after the frame_start edge are captured.
  task automatic frm(input bit rn, input logic [3:0] din, input bit pdf);
    tick(1'b1, rn, 1'b1, 1'b0, din);
    cap_dv = digit_valid;
    cap_fc = frame_cnt;
    fc_log.push_back(int'(frame_cnt));
    tick(1'b1, rn, 1'b0, pdf, din);
    tick(1'b1, rn, 1'b0, 1'b0, din);
  endtask

  // From HOLD (count 0): hold, hold->PROJ (done flagged), PROJ->RECOG, RECOG sample.
  task automatic round(input logic [3:0] din);
    frm(1'b1, din, 1'b0);
    frm(1'b1, din, 1'b1);
    frm(1'b1, din, 1'b0);
    frm(1'b1, din, 1'b0);
  endtask

  initial begin
    int         exp_seq[6];
    logic [3:0] seq_a[5];
    logic [3:0] seq_b[5];
    bit         exp_dv[5];
    logic [3:0] tgt;
    bit         rn, vs, pdf, r_n;
    logic [3:0] din;

    exp_seq = '{1, 2, 0, 0, 1, 2};
    seq_a   = '{4'd5, 4'd5, 4'd9, 4'd9, 4'd9};
    seq_b   = '{4'd3, 4'hC, 4'd3, 4'd3, 4'd3};
    exp_dv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with vsync held high: no frame_start on release.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("rst_digit", 16'(digit), 16'h000F);
    chk("rst_busy", 16'(busy), 16'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("no_fs_after_rst", 16'(frame_cnt), 16'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    frm(1'b1, 4'd0, 1'b1);
    chk("first_proj_fc", 16'(cap_fc), 16'd1);
    chk("first_proj_en", 16'(proj_en), 16'd1);
    chk("first_busy", 16'(busy), 16'd1);
    chk("first_err", 16'(err), 16'd0);
    frm(1'b1, 4'd7, 1'b0);
    frm(1'b1, 4'd7, 1'b0);
    chk("seven_1_dv", 16'(cap_dv), 16'd0);
    round(4'd7);
    chk("seven_2_dv", 16'(cap_dv), 16'd0);
    round(4'd7);
    chk("seven_3_dv", 16'(cap_dv), 16'd1);
    chk("seven_digit", 16'(digit), 16'd7);
    for (int i = 0; i < 6; i++) chk($sformatf("fc_seq[%0d]", i), 16'(fc_log[i]), 16'(exp_seq[i]));

    for (int i = 0; i < 5; i++) begin
      round(seq_a[i]);
      chk($sformatf("seq59_dv[%0d]", i), 16'(cap_dv), 16'(exp_dv[i]));
    end
    chk("seq59_digit", 16'(digit), 16'd9);
    for (int i = 0; i < 5; i++) begin
      round(seq_b[i]);
      chk($sformatf("seq3C_dv[%0d]", i), 16'(cap_dv), 16'(exp_dv[i]));
    end
    chk("seq3C_digit", 16'(digit), 16'd3);

    // Projection timeout.
    frm(1'b1, 4'd0, 1'b0);
    frm(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < MAX_RETRY - 1; i++) frm(1'b1, 4'd0, 1'b0);
    chk("retry_busy", 16'(busy), 16'd1);
    frm(1'b1, 4'd0, 1'b0);
    chk("timeout_err", 16'(err), 16'd1);
    chk("timeout_busy", 16'(busy), 16'd0);
    frm(1'b1, 4'd0, 1'b1);
    chk("reentry_err", 16'(err), 16'd0);
    chk("reentry_fc", 16'(cap_fc), 16'd1);

    // run dropped during RECOG, then reset mid-frame.
    frm(1'b1, 4'd4, 1'b0);
    frm(1'b0, 4'd4, 1'b0);
    chk("rundrop_busy", 16'(busy), 16'd0);
    chk("rundrop_digit", 16'(digit), 16'd3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    chk("midrst_digit", 16'(digit), 16'h000F);
    chk("midrst_en", 16'({proj_en, recog_en, frame_cnt}), 16'd0);
`ifdef RECOG_STAT_EN
    chk("midrst_recog_count", recog_count, 16'd0);
`endif

    // Randomised traffic.
    tgt = 4'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) tgt = 4'($urandom_range(0, 9));
      r_n = ($urandom_range(0, 499) != 0);
      rn  = ($urandom_range(0, 99) < 96);
      vs  = ($urandom_range(0, 2) == 0);
      pdf = ($urandom_range(0, 5) == 0);
      din = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : tgt;
      tick(r_n, rn, vs, pdf, din);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
